// File: rtl/seg7_capture.sv
// seg7_capture: reconstructs the hex value shown on a time-multiplexed,
// active-low 7-segment display bus and flags illegal segment patterns.
//
// Optional feature macro: SEG7_CAPTURE_BLANK_EN (all-segments-off is a
// legal blank instead of an illegal glyph).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   an           digit select, active-low, one bit low selects a digit
//   seg          segments, active-low, bit6=a .. bit0=g
//   clr          synchronous clear of captured state (same effect as rst)
//   value        captured nibbles, digit i at [4i+3:4i]
//   digit_valid  bit i set when nibble i holds a legal glyph
//   frame_done   one-cycle pulse when every digit has been captured
//   bad_pattern  one-cycle pulse when an accepted pattern is not a glyph
//   bad_digit    digit index of the last bad_pattern, held between pulses
module seg7_capture #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  bad_pattern,
  output logic [2:0]            bad_digit
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] seen;

  logic              same_c;
  logic [3:0]        nlow_c;
  logic [2:0]        idx_c;
  logic              accept_c;
  logic [4:0]        dec_c;
  logic              blank_c;
  logic [DIGITS-1:0] sel_c;
  logic [DIGITS-1:0] seen_upd_c;
  logic              full_c;

  // Glyph lookup: {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  // Accept decision; the incoming pair equals the registered pair whenever
  // an accept is possible, so the registered copy is decoded.
  always_comb begin
    same_c = (an == an_q) && (seg == seg_q);
    nlow_c = 4'd0;
    idx_c  = 3'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!an_q[i]) begin
        nlow_c = nlow_c + 4'd1;
        idx_c  = 3'(i);
      end
    end
    // cnt == STABLE_CYCLES-1 with a matching sample means it reaches
    // STABLE_CYCLES on this edge, which happens once per stable episode
    accept_c   = same_c && (cnt == CNT_LAST) && (nlow_c == 4'd1);
    dec_c      = decode(seg_q);
`ifdef SEG7_CAPTURE_BLANK_EN
    blank_c    = (seg_q == 7'h7F);
`else
    blank_c    = 1'b0;
`endif
    sel_c      = DIGITS'(1) << idx_c;
    seen_upd_c = seen | (accept_c ? sel_c : '0);
    full_c     = accept_c && (&seen_upd_c);
  end

  // Input stage, stability counter and captured state
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      an_q        <= '1;
      seg_q       <= '1;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      bad_digit   <= 3'd0;
    end else begin
      an_q        <= an;
      seg_q       <= seg;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      if (!same_c) begin
        cnt <= CW'(1);
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (accept_c) begin
        seen       <= full_c ? '0 : seen_upd_c;
        frame_done <= full_c;
        if (dec_c[4]) begin
          value[4*idx_c +: 4] <= dec_c[3:0];
          digit_valid[idx_c]  <= 1'b1;
        end else begin
          digit_valid[idx_c] <= 1'b0;
          if (!blank_c) begin
            bad_pattern <= 1'b1;
            bad_digit   <= idx_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned S      = 4;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_done, bad_pattern;
  logic [2:0]  bad_digit;

  always #5 clk = ~clk;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .clr(clr),
    .value(value), .digit_valid(digit_valid), .frame_done(frame_done),
    .bad_pattern(bad_pattern), .bad_digit(bad_digit)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model: run length of identical samples since reset
  logic [31:0] m_value;
  logic [7:0]  m_valid, m_seen;
  logic        m_fd, m_bad;
  logic [2:0]  m_bd;
  logic [14:0] m_last;
  int          m_run;
  int          n_fd, n_bad;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b0000001;  1: glyph = 7'b1001111;  2: glyph = 7'b0010010;
      3: glyph = 7'b0000110;  4: glyph = 7'b1001100;  5: glyph = 7'b0100100;
      6: glyph = 7'b0100000;  7: glyph = 7'b0001111;  8: glyph = 7'b0000000;
      9: glyph = 7'b0000100; 10: glyph = 7'b0001000; 11: glyph = 7'b1100000;
     12: glyph = 7'b0110001; 13: glyph = 7'b1000010; 14: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  function automatic int glyph_of(input logic [6:0] s);
    glyph_of = -1;
    for (int n = 0; n < 16; n++) if (glyph(n) == s) glyph_of = n;
  endfunction

  function automatic int low_index(input logic [7:0] a);
    int cnt = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++) if (!a[i]) begin cnt++; idx = i; end
    low_index = (cnt == 1) ? idx : -1;
  endfunction

  function automatic logic [7:0] an_of(input int d);
    an_of = ~(8'b1 << d);
  endfunction

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_seen = '0;
    m_fd = 1'b0; m_bad = 1'b0; m_bd = '0;
    m_last = '1; m_run = 0;
  endtask

  task automatic model_edge(input logic [7:0] a, input logic [6:0] s, input logic c, input logic r);
    int d, g;
    bit blank_ok;
    if (r || c) begin
      model_reset();
      return;
    end
    m_fd = 1'b0; m_bad = 1'b0;
    if ({a, s} == m_last) m_run++;
    else begin m_run = 1; m_last = {a, s}; end
    d = low_index(a);
    if (m_run == int'(S) && d >= 0) begin
      g = glyph_of(s);
`ifdef SEG7_CAPTURE_BLANK_EN
      blank_ok = (s == 7'h7F);
`else
      blank_ok = 1'b0;
`endif
      m_seen[d] = 1'b1;
      if (g >= 0) begin
        m_value[4*d +: 4] = 4'(g);
        m_valid[d] = 1'b1;
      end else begin
        m_valid[d] = 1'b0;
        if (!blank_ok) begin m_bad = 1'b1; m_bd = 3'(d); end
      end
      if (m_seen == 8'hFF) begin m_fd = 1'b1; m_seen = '0; end
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [6:0] s, input logic c, input logic r);
    an = a; seg = s; clr = c; rst = r;
    @(posedge clk);
    model_edge(a, s, c, r);
    #1;
    check("value", value, m_value);
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("bad_pattern", 32'(bad_pattern), 32'(m_bad));
    check("bad_digit", 32'(bad_digit), 32'(m_bd));
    n_fd  += int'(frame_done);
    n_bad += int'(bad_pattern);
  endtask

  task automatic hold(input int d, input logic [6:0] s, input int n);
    repeat (n) step(an_of(d), s, 1'b0, 1'b0);
  endtask

  logic [31:0] snap_v;
  logic [7:0]  snap_dv;
  logic [31:0] scan;

  initial begin
    model_reset();
    n_fd = 0; n_bad = 0;
    step('1, '1, 1'b0, 1'b1);
    step('1, '1, 1'b0, 1'b1);
    check("rst_value", value, 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_bad_digit", 32'(bad_digit), 32'h0);

    // Full scan of 1234ABCD, digit 0 first
    scan = 32'h1234ABCD;
    n_fd = 0;
    for (int d = 0; d < 8; d++) hold(d, glyph(int'(scan[4*d +: 4])), 8);
    check("scan_value", value, 32'h1234ABCD);
    check("scan_valid", 32'(digit_valid), 32'hFF);
    check("scan_frames", 32'(n_fd), 32'd1);

    // Short glitch of 8 on digit 3, then 5
    hold(3, 7'b0000000, 3);
    check("glitch_ignored", 32'(value[15:12]), 32'hA);
    hold(3, 7'b0100100, 8);
    check("glitch_then_5", 32'(value[15:12]), 32'h5);

    // Illegal glyph on digit 2
    n_bad = 0;
    hold(2, 7'b1111110, 6);
    check("bad_pulses", 32'(n_bad), 32'd1);
    check("bad_digit2", 32'(bad_digit), 32'd2);
    check("bad_valid2", 32'(digit_valid[2]), 32'd0);
    check("bad_value2", 32'(value[11:8]), 32'hB);

    // Two digits selected at once: never accepted
    snap_v = value; snap_dv = digit_valid; n_bad = 0; n_fd = 0;
    repeat (10) step(8'b11110011, 7'b0000001, 1'b0, 1'b0);
    check("multi_value", value, snap_v);
    check("multi_valid", 32'(digit_valid), 32'(snap_dv));
    check("multi_pulses", 32'(n_bad + n_fd), 32'd0);

    // clr on the accept edge of the last missing digit
    hold(0, glyph(1), 6); hold(1, glyph(2), 6); hold(4, glyph(3), 6);
    hold(6, glyph(4), 6); hold(7, glyph(5), 6);
    n_fd = 0;
    hold(5, glyph(6), int'(S) - 1);
    step(an_of(5), glyph(6), 1'b1, 1'b0);
    check("clr_value", value, 32'h0);
    check("clr_valid", 32'(digit_valid), 32'h0);
    check("clr_no_frame", 32'(n_fd), 32'd0);
    hold(5, glyph(6), 2);

    // Blank on digit 7
    hold(7, glyph(9), 6);
    n_bad = 0;
    hold(7, 7'h7F, 6);
    check("blank_valid7", 32'(digit_valid[7]), 32'd0);
`ifdef SEG7_CAPTURE_BLANK_EN
    check("blank_no_bad", 32'(n_bad), 32'd0);
`else
    check("blank_bad", 32'(n_bad), 32'd1);
    check("blank_bad_digit", 32'(bad_digit), 32'd7);
`endif

    // Randomized episodes
    for (int ep = 0; ep < 400; ep++) begin
      int d    = int'($urandom_range(0, 7));
      int kind = int'($urandom_range(0, 9));
      int n    = int'($urandom_range(1, 8));
      logic [7:0] a = (kind == 0) ? 8'($urandom) : an_of(d);
      logic [6:0] s = (kind < 7) ? glyph(int'($urandom_range(0, 15))) : 7'($urandom);
      for (int k = 0; k < n; k++)
        step(a, s, ($urandom_range(0, 99) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
